// File: rtl/audio_pkg.sv
// Shared types and constants for the audio mixer: FSM states and the fixed weights
// of the speaker/tape mix and gain scaling.
package audio_pkg;

    typedef enum logic [2:0] {
        IDLE,
        ACC_SPK,
        ACC_TAPE,
        SCALE,
        OUT
    } state_t;

    localparam logic [7:0] MIDSCALE    = 8'd128;
    localparam logic [4:0] GAIN_MAX    = 5'd16;
    localparam int         GAIN_SHIFT  = 4;
    localparam int         SPK_WEIGHT  = 3;
    localparam logic [8:0] TAPE_WEIGHT = 9'd32;

endpackage

// File: rtl/audio_mixer_if.sv
// Sample-strobe bus between the audio source logic (master) and the mixer (slave).
interface audio_mixer_if;
    import audio_pkg::*;

    logic       ce;
    logic [5:0] spk;
    logic       ear;
    logic       mic;
    logic       mute;
    logic       busy;
    logic       valid;
    logic [7:0] do_value;   // excess-128 sample for the DAC di input

    modport master (output ce, spk, ear, mic, mute, input busy, valid, do_value);
    modport slave  (input ce, spk, ear, mic, mute, output busy, valid, do_value);

endinterface

// File: rtl/audio_gain_ramp.sv
// Gain ramp: steps gain by one toward 0 (muted) or GAIN_MAX (unmuted) once per
// RAMP_DIV accepted samples, so mute/unmute changes never pop.
module audio_gain_ramp
    import audio_pkg::*;
#(
    parameter int RAMP_DIV = 64
) (
    input  logic       clock,
    input  logic       reset,
    input  logic       step,
    input  logic       mute,
    output logic [4:0] gain
);

    localparam int             CW   = (RAMP_DIV > 1) ? $clog2(RAMP_DIV) : 1;
    localparam logic [CW-1:0]  LAST = CW'(RAMP_DIV - 1);

    logic [CW-1:0] count_reg;
    logic [4:0]    gain_reg;

    always_ff @(posedge clock) begin
        if (!reset) begin
            count_reg <= '0;
            gain_reg  <= '0;
        end else if (step) begin
            if (count_reg == LAST) begin
                count_reg <= '0;
                if (!mute && (gain_reg < GAIN_MAX))
                    gain_reg <= gain_reg + 5'd1;
                else if (mute && (gain_reg != 5'd0))
                    gain_reg <= gain_reg - 5'd1;
            end else begin
                count_reg <= count_reg + 1'b1;
            end
        end
    end

    assign gain = gain_reg;

endmodule

// File: rtl/audio_mixer.sv
// Mixes the 6-bit speaker DAC value and tape EAR/MIC bits into one excess-128
// sample through a 4-step FSM that reuses a single 9-bit adder.
module audio_mixer
    import audio_pkg::*;
#(
    parameter int RAMP_DIV = 64
) (
    input  logic          clock,
    input  logic          reset,
    audio_mixer_if.slave  bus
);

    state_t            state_reg;
    logic [5:0]        spk_reg;
    logic              ear_reg;
    logic              mic_reg;
    logic              mute_reg;
    logic [8:0]        acc_reg;
    logic signed [13:0] prod_reg;
    logic [7:0]        do_reg;
    logic              valid_reg;
    logic              busy_reg;

    logic [4:0]        gain;
    logic              step;
    logic [8:0]        add_a;
    logic [8:0]        add_b;
    logic [8:0]        sum;
    logic signed [13:0] s_ext;
    logic signed [13:0] gain_ext;
    logic signed [13:0] prod_next;

    assign step = (state_reg == OUT);

    audio_gain_ramp #(.RAMP_DIV(RAMP_DIV)) u_ramp (
        .clock (clock),
        .reset (reset),
        .step  (step),
        .mute  (mute_reg),
        .gain  (gain)
    );

    // One adder serves every stage; operands are selected by the current state.
    always_comb begin
        add_a = '0;
        add_b = '0;
        case (state_reg)
            ACC_SPK: begin
                add_a = {3'b000, spk_reg};
                add_b = {2'b00, spk_reg, 1'b0};
            end
            ACC_TAPE: begin
                add_a = acc_reg;
                add_b = (ear_reg ? TAPE_WEIGHT : 9'd0) + (mic_reg ? TAPE_WEIGHT : 9'd0);
            end
            SCALE: begin
                add_a = acc_reg;
                add_b = 9'h180;     // -128 in 9-bit two's complement
            end
            OUT: begin
                add_a = 9'(prod_reg >>> GAIN_SHIFT);
                add_b = {1'b0, MIDSCALE};
            end
            default: begin
                add_a = '0;
                add_b = '0;
            end
        endcase
    end

    assign sum       = add_a + add_b;
    assign s_ext     = {{5{sum[8]}}, sum};
    assign gain_ext  = {9'b0, gain};
    assign prod_next = s_ext * gain_ext;

    always_ff @(posedge clock) begin
        if (!reset) begin
            state_reg <= IDLE;
            spk_reg   <= '0;
            ear_reg   <= 1'b0;
            mic_reg   <= 1'b0;
            mute_reg  <= 1'b0;
            acc_reg   <= '0;
            prod_reg  <= '0;
            do_reg    <= MIDSCALE;
            valid_reg <= 1'b0;
            busy_reg  <= 1'b0;
        end else begin
            valid_reg <= 1'b0;
            case (state_reg)
                IDLE: begin
                    if (bus.ce) begin
                        spk_reg   <= bus.spk;
                        ear_reg   <= bus.ear;
                        mic_reg   <= bus.mic;
                        mute_reg  <= bus.mute;
                        busy_reg  <= 1'b1;
                        state_reg <= ACC_SPK;
                    end
                end
                ACC_SPK: begin
                    acc_reg   <= sum;
                    state_reg <= ACC_TAPE;
                end
                ACC_TAPE: begin
                    acc_reg   <= sum;
                    state_reg <= SCALE;
                end
                SCALE: begin
                    prod_reg  <= prod_next;
                    state_reg <= OUT;
                end
                OUT: begin
                    do_reg    <= sum[7:0];
                    valid_reg <= 1'b1;
                    busy_reg  <= 1'b0;
                    state_reg <= IDLE;
                end
                default: begin
                    busy_reg  <= 1'b0;
                    state_reg <= IDLE;
                end
            endcase
        end
    end

    assign bus.busy     = busy_reg;
    assign bus.valid    = valid_reg;
    assign bus.do_value = do_reg;

endmodule
